hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Controller for the EX-stage operand forwarding muxes (3-to-1, 32-bit) and the pipeline write-enables in the 5-stage MIPS core. It keeps a shadow copy of destination-register state for ID/EX, EX/MEM and MEM/WB and uses it to drive the two 2-bit forwarding selects. It also detects load-use hazards and inserts one bubble. It freezes the whole pipeline while the data memory reports busy.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- PERF_W, 32, width of perf counters (when compiled in)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high
- id_rs, id_rt  input  REG_W  source specifiers of instruction in ID
- id_uses_rs, id_uses_rt  input  1  ID instruction actually reads rs / rt
- id_dest  input  REG_W  final destination (post RegDst mux) of ID instruction
- id_reg_write  input  1  ID instruction writes register file
- id_mem_read  input  1  ID instruction is a load
- id_flush  input  1  branch/jump taken; squash instruction in ID
- mem_busy  input  1  data memory stall request
- fwd_a_sel, fwd_b_sel  output  2  operand A/B mux control: 00 regfile, 01 MEM/WB value, 10 EX/MEM ALU result
- pc_write_en  output  1  PC may update
- ifid_write_en  output  1  IF/ID register may update
- idex_bubble  output  1  load zeros into ID/EX control fields
- pipe_freeze  output  1  hold all pipeline registers
- stall_cycles, freeze_cycles  output  PERF_W  perf counters (HAZARD_PERF_EN only)

## Operation
- Shadow registers: ex_{rs,rt,dest,reg_write,mem_read}, mem_{dest,reg_write}, wb_{dest,reg_write}. They advance every cycle unless frozen; the ex_* fields load from id_* inputs.
- Bubble: if idex_bubble is set, ex_reg_write and ex_mem_read load 0. ex_dest, ex_rs and ex_rt load 0.
- Forward select per operand (shown for A using ex_rs; B uses ex_rt):
  - 10 if mem_reg_write && mem_dest!=0 && mem_dest==ex_rs;
  - else 01 if wb_reg_write && wb_dest!=0 && wb_dest==ex_rs;
  - else 00.
  - 11 is never driven.
  - Selects are decoded from shadow registers only; there is no path from inputs.
- Load-use detect (LU): ex_mem_read && ex_dest!=0 && ((id_uses_rs && id_rs==ex_dest) || (id_uses_rt && id_rt==ex_dest)).
- FSM states:
  - RUN: normal flow.
  - FREEZE: entered from RUN when mem_busy=1. While frozen, pipe_freeze=1 and pc_write_en=ifid_write_en=0; shadow registers hold and the selects stay stable. Returns to RUN in the cycle after mem_busy=0 is sampled.
  - STALL: entered from RUN on LU && !id_flush && !mem_busy. In that cycle pc_write_en=ifid_write_en=0 and idex_bubble=1. The state lasts exactly 1 cycle, then returns to RUN. LU cannot re-assert because the bubble cleared ex_mem_read.
- Priority: mem_busy beats id_flush, which beats LU. When id_flush=1, the squashed ID instruction enters EX as a bubble (idex_bubble=1). No PC hold occurs on flush.
- Reset: state RUN; all shadow fields 0; counters 0.

## Timing
- Reset values: fwd_a_sel=fwd_b_sel=00, pc_write_en=ifid_write_en=1, idex_bubble=0, pipe_freeze=0.
- Forward selects are valid from the clock edge on which the consumer enters EX. This is zero added latency.
- LU stall costs exactly 1 cycle. The dependent instruction then sees fwd sel=01 (load data in MEM/WB).
- pipe_freeze asserts combinationally in the same cycle mem_busy=1 (RUN) and holds through FREEZE.
- If mem_busy rises during STALL, the freeze takes priority: the bubble is still written, then the pipeline holds.
- Reset asserted mid-stall or mid-freeze returns the block to RUN on the next edge.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles increments each STALL cycle. freeze_cycles increments each cycle pipe_freeze=1. Both saturate at all-ones and clear on reset.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- add $3 written in EX/MEM, next instruction reads $3 as rs -> fwd_a_sel=10, fwd_b_sel=00.
- Writer 2 instructions ahead to $5, reader uses $5 as rt -> fwd_b_sel=01. If both EX/MEM and MEM/WB write $5 -> 10 (priority).
- Write to $0 followed by a read of $0 -> selects stay 00.
- lw $4 then add using $4 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1, then fwd sel=01. stall_cycles=1 when HAZARD_PERF_EN.
- Load-use with id_flush=1 in the same cycle -> no stall, idex_bubble=1, pc_write_en=1.
- mem_busy high for 3 cycles mid-stream -> pipe_freeze=1 for 3 cycles with selects unchanged. freeze_cycles=3. Reset pulsed during the freeze -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX-stage forwarding select, load-use stall and memory freeze control
//
// Tracks destination-register state for ID/EX, EX/MEM and MEM/WB in shadow
// flops, decodes the two operand-forwarding mux selects from them, inserts a
// one-cycle bubble on load-use, and holds the whole pipeline while the data
// memory is busy.
//
// Optional feature macro: HAZARD_PERF_EN (adds stall_cycles / freeze_cycles).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_rs, id_rt                  source specifiers of the ID instruction
//   id_uses_rs, id_uses_rt        ID instruction really reads rs / rt
//   id_dest, id_reg_write         ID destination and register-write flag
//   id_mem_read                   ID instruction is a load
//   id_flush                      squash the ID instruction (taken branch/jump)
//   mem_busy                      data memory stall request
//   fwd_a_sel, fwd_b_sel          00 regfile, 01 MEM/WB, 10 EX/MEM
//   pc_write_en, ifid_write_en    PC / IF-ID update enables
//   idex_bubble                   zero the ID/EX control fields
//   pipe_freeze                   hold every pipeline register
//   stall_cycles, freeze_cycles   saturating perf counters (HAZARD_PERF_EN)
module hazard_forward_ctrl #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_flush,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_bubble,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] freeze_cycles,
`endif
  output logic              pipe_freeze
);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FREEZE} state_t;

  state_t state_q, state_d;

  logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dest_q, ex_dest_d;
  logic             ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
  logic             mem_reg_write_q, mem_reg_write_d, wb_reg_write_q, wb_reg_write_d;

  logic load_use;

  // The bubble written on entering STALL clears ex_mem_read, so load-use is
  // only meaningful outside STALL; masking it here makes that explicit.
  always_comb begin
    load_use = ex_mem_read_q && (ex_dest_q != '0) && (state_q != ST_STALL) &&
               ((id_uses_rs && (id_rs == ex_dest_q)) ||
                (id_uses_rt && (id_rt == ex_dest_q)));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: mem_busy beats id_flush, which beats load-use
  always_comb begin
    state_d = ST_RUN;
    if (mem_busy)                   state_d = ST_FREEZE;
    else if (id_flush)              state_d = ST_RUN;
    else if (load_use)              state_d = ST_STALL;
  end

  // Output logic: Mealy on the same priority so the bubble lands on the edge
  // that would otherwise move the dependent instruction into EX.
  always_comb begin
    pipe_freeze   = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    if (mem_busy) begin
      pipe_freeze   = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end else if (id_flush) begin
      idex_bubble   = 1'b1;
    end else if (load_use) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end
  end

  // Shadow pipeline advance
  always_comb begin
    ex_rs_d         = ex_rs_q;
    ex_rt_d         = ex_rt_q;
    ex_dest_d       = ex_dest_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    mem_dest_d      = mem_dest_q;
    mem_reg_write_d = mem_reg_write_q;
    wb_dest_d       = wb_dest_q;
    wb_reg_write_d  = wb_reg_write_q;
    if (!pipe_freeze) begin
      wb_dest_d       = mem_dest_q;
      wb_reg_write_d  = mem_reg_write_q;
      mem_dest_d      = ex_dest_q;
      mem_reg_write_d = ex_reg_write_q;
      if (idex_bubble) begin
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_dest_d      = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
      end else begin
        ex_rs_d        = id_rs;
        ex_rt_d        = id_rt;
        ex_dest_d      = id_dest;
        ex_reg_write_d = id_reg_write;
        ex_mem_read_d  = id_mem_read;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dest_q       <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_dest_q      <= '0;
      mem_reg_write_q <= 1'b0;
      wb_dest_q       <= '0;
      wb_reg_write_q  <= 1'b0;
    end else begin
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      wb_dest_q       <= wb_dest_d;
      wb_reg_write_q  <= wb_reg_write_d;
    end
  end

  // Forward selects come from shadow state only; EX/MEM wins over MEM/WB
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (mem_reg_write_q && (mem_dest_q != '0) && (mem_dest_q == ex_rs_q))
      fwd_a_sel = 2'b10;
    else if (wb_reg_write_q && (wb_dest_q != '0) && (wb_dest_q == ex_rs_q))
      fwd_a_sel = 2'b01;
    if (mem_reg_write_q && (mem_dest_q != '0) && (mem_dest_q == ex_rt_q))
      fwd_b_sel = 2'b10;
    else if (wb_reg_write_q && (wb_dest_q != '0) && (wb_dest_q == ex_rt_q))
      fwd_b_sel = 2'b01;
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] freeze_cycles_q, freeze_cycles_d;

  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    freeze_cycles_d = freeze_cycles_q;
    if ((state_q == ST_STALL) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (pipe_freeze && (freeze_cycles_q != '1))
      freeze_cycles_d = freeze_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= '0;
      freeze_cycles_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      freeze_cycles_q <= freeze_cycles_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_flush, mem_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_write_en, ifid_write_en, idex_bubble, pipe_freeze;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, freeze_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_W(5), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_flush(id_flush), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_bubble(idex_bubble),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles),
`endif
    .pipe_freeze(pipe_freeze)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Put an instruction in ID: rs, rt, uses_rs, uses_rt, dest, reg_write, mem_read
  task automatic put(input int rs, input int rt, input bit urs, input bit urt,
                     input int dest, input bit rw, input bit mr);
    id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled at the falling edge
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; id_flush = 1'b0; mem_busy = 1'b0;
    nop();
    repeat (2) tick();
    reset = 1'b0;
    sample();
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_pc_we", pc_write_en, 1);
    chk("rst_ifid_we", ifid_write_en, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_freeze", pipe_freeze, 0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall_cnt", stall_cycles, 0);
    chk("rst_freeze_cnt", freeze_cycles, 0);
`endif

    // add $3 then reader of $3 as rs (rt=$7 untouched)
    tick();
    put(1, 2, 1, 1, 3, 1, 0); tick();
    put(3, 7, 1, 1, 9, 1, 0); tick();
    nop(); sample();
    chk("exmem_fwd_a", fwd_a_sel, 2);
    chk("exmem_fwd_b", fwd_b_sel, 0);
    drain();

    // writer of $5 two ahead, reader uses $5 as rt
    put(1, 2, 1, 1, 5, 1, 0); tick();
    nop(); tick();
    put(0, 5, 0, 1, 8, 1, 0); tick();
    nop(); sample();
    chk("memwb_fwd_b", fwd_b_sel, 1);
    chk("memwb_fwd_a", fwd_a_sel, 0);
    drain();

    // both EX/MEM and MEM/WB write $5: EX/MEM wins
    put(1, 2, 1, 1, 5, 1, 0); tick();
    put(1, 2, 1, 1, 5, 1, 0); tick();
    put(0, 5, 0, 1, 8, 1, 0); tick();
    nop(); sample();
    chk("prio_fwd_b", fwd_b_sel, 2);
    drain();

    // write to $0 then read of $0
    put(1, 2, 1, 1, 0, 1, 0); tick();
    put(0, 0, 1, 1, 4, 1, 0); tick();
    nop(); sample();
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);
    drain();

    // lw $4 then add using $4 as rs
    put(1, 0, 1, 0, 4, 1, 1); tick();
    put(4, 2, 1, 1, 6, 1, 0); sample();
    chk("lu_pc_we", pc_write_en, 0);
    chk("lu_ifid_we", ifid_write_en, 0);
    chk("lu_bubble", idex_bubble, 1);
    tick(); sample();
    chk("lu_after_pc_we", pc_write_en, 1);
    chk("lu_after_bubble", idex_bubble, 0);
    tick();
    nop(); sample();
    chk("lu_fwd_a", fwd_a_sel, 1);
`ifdef HAZARD_PERF_EN
    chk("lu_stall_cnt", stall_cycles, 1);
`endif
    drain();

    // load-use together with flush: bubble, no PC hold
    put(1, 0, 1, 0, 4, 1, 1); tick();
    put(4, 2, 1, 1, 6, 1, 0); id_flush = 1'b1; sample();
    chk("fl_bubble", idex_bubble, 1);
    chk("fl_pc_we", pc_write_en, 1);
    chk("fl_ifid_we", ifid_write_en, 1);
    tick();
    id_flush = 1'b0; nop(); sample();
    chk("fl_next_pc_we", pc_write_en, 1);
    chk("fl_next_fwd_a", fwd_a_sel, 0);
    drain();

    // mem_busy for 3 cycles with a live EX/MEM forward
    put(1, 2, 1, 1, 6, 1, 0); tick();
    put(6, 0, 1, 0, 7, 1, 0); tick();
    nop(); mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("frz%0d_freeze", i), pipe_freeze, 1);
      chk($sformatf("frz%0d_pc_we", i), pc_write_en, 0);
      chk($sformatf("frz%0d_fwd_a", i), fwd_a_sel, 2);
      tick();
    end
    mem_busy = 1'b0; sample();
    chk("frz_end_freeze", pipe_freeze, 0);
    chk("frz_end_fwd_a", fwd_a_sel, 2);
`ifdef HAZARD_PERF_EN
    chk("frz_cnt", freeze_cycles, 3);
`endif

    // reset pulsed in the middle of a freeze
    put(6, 6, 1, 1, 6, 1, 0); tick();
    mem_busy = 1'b1; tick();
    reset = 1'b1; mem_busy = 1'b0; nop(); tick();
    reset = 1'b0; sample();
    chk("rfz_fwd_a", fwd_a_sel, 0);
    chk("rfz_fwd_b", fwd_b_sel, 0);
    chk("rfz_pc_we", pc_write_en, 1);
    chk("rfz_ifid_we", ifid_write_en, 1);
    chk("rfz_bubble", idex_bubble, 0);
    chk("rfz_freeze", pipe_freeze, 0);
`ifdef HAZARD_PERF_EN
    chk("rfz_freeze_cnt", freeze_cycles, 0);
    chk("rfz_stall_cnt", stall_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
